pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the fetch stage of the single-cycle and pipelined cores. It holds the current fetch address, advances it by a fixed step each cycle, and handles stalls, taken branches/jumps, traps and misaligned targets with a fixed priority. An optional return-address stack (RAS) predicts return targets for call/return pairs. Instruction memory and the branch unit consume `pc_o`/`pc_plus_o`.

## Interface
- `WIDTH`, 32: PC width in bits.
- `STEP`, 4: sequential increment in bytes, a power of two; alignment mask is `STEP-1`.
- `RESET_VEC`, 0: PC value after reset.
- `TRAP_VEC`, 'h10: PC loaded on trap or misaligned redirect.
- `RAS_DEPTH`, 4: RAS entries, ≥2, power of two.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall_i`  in  1  hold PC (fetch not accepted).
- `redirect_i`  in  1  load `target_i` (taken branch/jump).
- `target_i`  in  WIDTH  redirect target.
- `trap_i`  in  1  load `TRAP_VEC`.
- `call_i`  in  1  qualified by `redirect_i`: push `pc_plus_o` to RAS.
- `ret_i`  in  1  pop RAS top into PC.
- `pc_o`  out  WIDTH  current PC, registered.
- `pc_plus_o`  out  WIDTH  `pc_o + STEP` mod 2^WIDTH, combinational.
- `misalign_o`  out  1  registered one-cycle pulse after a misaligned redirect.
- `ras_empty_o`, `ras_full_o`  out  1  registered RAS occupancy flags.

## Operation
- Next-PC priority, highest first: `reset` → `RESET_VEC`; `trap_i` → `TRAP_VEC`; `redirect_i` → `target_i`, or `TRAP_VEC` with `misalign_o`=1 next cycle if `target_i & (STEP-1)` ≠ 0; `ret_i` with RAS non-empty → RAS top, pop; `stall_i` → hold; else → `pc_plus_o`.
- `trap_i` and `redirect_i` override `stall_i`; `ret_i` is ignored while `stall_i`=1.
- `ret_i` with RAS empty: ignored, PC follows stall/increment rules, no flag.
- Push occurs only when `call_i`&`redirect_i`, no trap, target aligned. Pushed value: `pc_plus_o` of that cycle.
- Push when full: overwrite oldest entry (circular), `ras_full_o` stays 1, depth unchanged.
- `call_i` without `redirect_i`: ignored. `call_i` and `ret_i` together: push wins, no pop.
- Trap and misaligned redirect leave RAS contents unchanged.
- Increment wraps modulo 2^WIDTH with no flag.

## Timing
- Reset values: `pc_o`=`RESET_VEC`, `misalign_o`=0, `ras_empty_o`=1, `ras_full_o`=0, RAS pointer/count=0.
- Reset asserted mid-operation wins over every other input in that cycle.
- Redirect, trap, return latency: inputs sampled at edge N, new `pc_o` visible after edge N, i.e. one cycle.
- `misalign_o` high exactly one cycle, the same cycle `pc_o`=`TRAP_VEC`.
- RAS flags update on the same edge as the push/pop.
- `pc_plus_o` tracks `pc_o` with zero cycles of latency.

## Configuration
- `PC_RAS_EN` defined: RAS, `call_i`/`ret_i` behaviour as above.
- Undefined: no RAS storage. `call_i`/`ret_i` are ignored but the ports are kept. `ras_empty_o` is tied to 1 and `ras_full_o` to 0. All other behaviour is identical.

## Structure
- `pc_pkg`: parameter defaults. Also holds enum `pc_src_e` {`SRC_RESET`, `SRC_TRAP`, `SRC_REDIR`, `SRC_MISAL`, `SRC_RET`, `SRC_HOLD`, `SRC_SEQ`} for the next-PC select, exported for debug.
- Sub-module `ras_stack` (params `WIDTH`, `RAS_DEPTH`): circular LIFO with push/pop/top/empty/full. It is instantiated only under `PC_RAS_EN`.

## Test plan
All scenarios use `WIDTH`=8, `STEP`=4, `RESET_VEC`=0, `TRAP_VEC`=F0, `RAS_DEPTH`=2.
- Reset 1 cycle, then free-run 70 cycles → `pc_o` = 00,04,08…FC,00 (wraps); `pc_plus_o` is always `pc_o`+4.
- At `pc_o`=10, `stall_i`=1 for 3 cycles → holds 10, then 14. Redirect to 40 during the stall → 40 the next cycle.
- Redirect to 42 → `pc_o`=F0 and `misalign_o`=1 for one cycle; RAS is unchanged.
- Trap, redirect to 40 and `ret_i` in the same cycle → F0. Reset in that cycle as well → 00.
- At `pc_o`=20, call to 80; at 84, call to C0; at C4, `ret_i` → 88; next `ret_i` → 24 with `ras_empty_o`=1; a further `ret_i` is ignored → 28.
- Three calls from 20, 30 and 40 with depth 2 → pops return 44 then 34, `ras_full_o` 1→0→0; with `PC_RAS_EN` undefined, `ret_i` is ignored.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared defaults and next-PC source encoding for the fetch-stage program counter.
package pc_pkg;

   localparam int unsigned PC_WIDTH     = 32;
   localparam int unsigned PC_STEP      = 4;
   localparam int unsigned PC_RESET_VEC = 0;
   localparam int unsigned PC_TRAP_VEC  = 'h10;
   localparam int unsigned PC_RAS_DEPTH = 4;

   // Next-PC select, highest priority first; exported for debug visibility.
   typedef enum logic [2:0] {
      SRC_RESET,
      SRC_TRAP,
      SRC_REDIR,
      SRC_MISAL,
      SRC_RET,
      SRC_HOLD,
      SRC_SEQ
   } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module ras_stack
   import pc_pkg::*;
#(
   parameter int unsigned WIDTH     = PC_WIDTH,
   parameter int unsigned RAS_DEPTH = PC_RAS_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] top_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   logic [WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));
   // ptr_q names the next free slot; depth is a power of two so the index wraps naturally.
   assign top_o   = mem_q[ptr_q - PTR_W'(1)];

   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (push_i) begin
         ptr_d = ptr_q + PTR_W'(1);
         if (!full_o) cnt_d = cnt_q + CNT_W'(1);
      end else if (pop_i && !empty_o) begin
         ptr_d = ptr_q - PTR_W'(1);
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[ptr_q] <= data_i;
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with fixed-priority redirect/trap/return handling.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH     = PC_WIDTH,
   parameter int unsigned      STEP      = PC_STEP,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
   parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(PC_TRAP_VEC),
   parameter int unsigned      RAS_DEPTH = PC_RAS_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_i,
   input  logic             redirect_i,
   input  logic [WIDTH-1:0] target_i,
   input  logic             trap_i,
   input  logic             call_i,
   input  logic             ret_i,
   output logic [WIDTH-1:0] pc_o,
   output logic [WIDTH-1:0] pc_plus_o,
   output logic             misalign_o,
   output logic             ras_empty_o,
   output logic             ras_full_o
);

   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             misalign_q, misalign_d;
   logic [WIDTH-1:0] ras_top;
   logic             ras_empty, ras_full;
   pc_src_e          src;

   assign pc_o        = pc_q;
   assign pc_plus_o   = pc_q + WIDTH'(STEP);
   assign misalign_o  = misalign_q;
   assign ras_empty_o = ras_empty;
   assign ras_full_o  = ras_full;

   always_comb begin
      if (reset)                              src = SRC_RESET;
      else if (trap_i)                        src = SRC_TRAP;
      else if (redirect_i)                    src = |(target_i & ALIGN_MASK) ? SRC_MISAL : SRC_REDIR;
      else if (ret_i && !stall_i && !ras_empty) src = SRC_RET;
      else if (stall_i)                       src = SRC_HOLD;
      else                                    src = SRC_SEQ;
   end

   always_comb begin
      pc_d       = pc_plus_o;
      misalign_d = 1'b0;
      unique case (src)
         SRC_RESET: pc_d = RESET_VEC;
         SRC_TRAP:  pc_d = TRAP_VEC;
         SRC_REDIR: pc_d = target_i;
         SRC_MISAL: begin
            pc_d       = TRAP_VEC;
            misalign_d = 1'b1;
         end
         SRC_RET:   pc_d = ras_top;
         SRC_HOLD:  pc_d = pc_q;
         default:   pc_d = pc_plus_o;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_VEC;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

`ifdef PC_RAS_EN
   logic ras_push, ras_pop;

   // Only an aligned, untrapped call pushes; a simultaneous return loses to it via src.
   assign ras_push = call_i && (src == SRC_REDIR);
   assign ras_pop  = (src == SRC_RET);

   ras_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras_stack (
      .clk     (clk),
      .reset   (reset),
      .push_i  (ras_push),
      .pop_i   (ras_pop),
      .data_i  (pc_plus_o),
      .top_o   (ras_top),
      .empty_o (ras_empty),
      .full_o  (ras_full)
   );
`else
   logic unused_call;

   assign unused_call = call_i;
   assign ras_top     = '0;
   assign ras_empty   = 1'b1;
   assign ras_full    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (WIDTH=8, STEP=4, TRAP_VEC=F0, RAS_DEPTH=2).
module tb_pc_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       stall_i;
   logic       redirect_i;
   logic [7:0] target_i;
   logic       trap_i;
   logic       call_i;
   logic       ret_i;
   logic [7:0] pc_o;
   logic [7:0] pc_plus_o;
   logic       misalign_o;
   logic       ras_empty_o;
   logic       ras_full_o;

   int checks = 0;
   int errors = 0;

   pc_unit #(
      .WIDTH     (8),
      .STEP      (4),
      .RESET_VEC (8'h00),
      .TRAP_VEC  (8'hF0),
      .RAS_DEPTH (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stall_i     (stall_i),
      .redirect_i  (redirect_i),
      .target_i    (target_i),
      .trap_i      (trap_i),
      .call_i      (call_i),
      .ret_i       (ret_i),
      .pc_o        (pc_o),
      .pc_plus_o   (pc_plus_o),
      .misalign_o  (misalign_o),
      .ras_empty_o (ras_empty_o),
      .ras_full_o  (ras_full_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      reset = 0; stall_i = 0; redirect_i = 0; target_i = '0;
      trap_i = 0; call_i = 0; ret_i = 0;
   endtask

   task automatic go(input logic [7:0] tgt, input logic call);
      redirect_i = 1; target_i = tgt; call_i = call;
      tick();
      redirect_i = 0; call_i = 0;
   endtask

   initial begin
      logic [7:0] exp_pc;

      idle();
      reset = 1;
      tick();
      chk("reset_pc", pc_o, 8'h00);
      chk("reset_misalign", {7'd0, misalign_o}, 8'h00);
      chk("reset_empty", {7'd0, ras_empty_o}, 8'h01);
      chk("reset_full", {7'd0, ras_full_o}, 8'h00);
      reset = 0;

      // Free-run across the 8-bit wrap.
      exp_pc = 8'h00;
      for (int i = 1; i <= 70; i++) begin
         tick();
         exp_pc = exp_pc + 8'h04;
         chk("seq_pc", pc_o, exp_pc);
         chk("seq_plus", pc_plus_o, exp_pc + 8'h04);
      end
      chk("seq_end", pc_o, 8'h18);

      // Stall holds for three cycles, then increments.
      go(8'h10, 1'b0);
      chk("redir_10", pc_o, 8'h10);
      stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_hold", pc_o, 8'h10);
      end
      stall_i = 0;
      tick();
      chk("stall_release", pc_o, 8'h14);

      // Redirect overrides a stall.
      stall_i = 1;
      tick();
      chk("stall_hold2", pc_o, 8'h14);
      go(8'h40, 1'b0);
      chk("redir_in_stall", pc_o, 8'h40);
      stall_i = 0;
      tick();
      chk("after_redir", pc_o, 8'h44);

      // Misaligned redirect.
      go(8'h42, 1'b0);
      chk("misal_pc", pc_o, 8'hF0);
      chk("misal_flag", {7'd0, misalign_o}, 8'h01);
      chk("misal_empty", {7'd0, ras_empty_o}, 8'h01);
      tick();
      chk("misal_drop", {7'd0, misalign_o}, 8'h00);
      chk("misal_next", pc_o, 8'hF4);

      // Trap beats redirect and return; reset beats everything.
      trap_i = 1; redirect_i = 1; target_i = 8'h40; ret_i = 1;
      tick();
      chk("trap_prio", pc_o, 8'hF0);
      chk("trap_nomisal", {7'd0, misalign_o}, 8'h00);
      reset = 1;
      tick();
      chk("reset_prio", pc_o, 8'h00);
      idle();
      tick();
      chk("post_reset", pc_o, 8'h04);

`ifdef PC_RAS_EN
      // Nested call/return, then return on empty stack.
      go(8'h20, 1'b0);
      go(8'h80, 1'b1);
      chk("call1_pc", pc_o, 8'h80);
      chk("call1_empty", {7'd0, ras_empty_o}, 8'h00);
      tick();
      chk("call1_seq", pc_o, 8'h84);
      go(8'hC0, 1'b1);
      chk("call2_full", {7'd0, ras_full_o}, 8'h01);
      tick();
      ret_i = 1;
      tick();
      chk("ret1_pc", pc_o, 8'h88);
      chk("ret1_full", {7'd0, ras_full_o}, 8'h00);
      tick();
      chk("ret2_pc", pc_o, 8'h24);
      chk("ret2_empty", {7'd0, ras_empty_o}, 8'h01);
      tick();
      chk("ret3_ignored", pc_o, 8'h28);
      ret_i = 0;

      // Misaligned call leaves the stack untouched.
      go(8'h20, 1'b0);
      go(8'h42, 1'b1);
      chk("mcall_pc", pc_o, 8'hF0);
      chk("mcall_empty", {7'd0, ras_empty_o}, 8'h01);

      // Overflow overwrites the oldest entry.
      go(8'h20, 1'b0);
      go(8'h30, 1'b1);
      go(8'h40, 1'b1);
      go(8'h80, 1'b1);
      chk("ovf_full", {7'd0, ras_full_o}, 8'h01);
      ret_i = 1;
      tick();
      chk("ovf_ret1", pc_o, 8'h44);
      chk("ovf_full1", {7'd0, ras_full_o}, 8'h00);
      tick();
      chk("ovf_ret2", pc_o, 8'h34);
      chk("ovf_full2", {7'd0, ras_full_o}, 8'h00);
      chk("ovf_empty", {7'd0, ras_empty_o}, 8'h01);
      tick();
      chk("ovf_ret3", pc_o, 8'h38);
      ret_i = 0;
`else
      // Without the stack, call and return are inert.
      go(8'h80, 1'b1);
      chk("nras_call_pc", pc_o, 8'h80);
      chk("nras_empty", {7'd0, ras_empty_o}, 8'h01);
      chk("nras_full", {7'd0, ras_full_o}, 8'h00);
      ret_i = 1;
      tick();
      chk("nras_ret", pc_o, 8'h84);
      tick();
      chk("nras_ret2", pc_o, 8'h88);
      ret_i = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
